// File: rtl/itr_ctrl.sv
// itr_ctrl: multi-source vectored interrupt controller with nesting.
// Prioritises NITR maskable request lines, drives a one-cycle itr pulse with a
// per-source vector address, and keeps a hardware return-address stack so
// interrupts can nest up to NEST levels deep.
module itr_ctrl #(
  parameter int MINSTW = 9,    // instruction address width
  parameter int NITR   = 4,    // number of interrupt sources
  parameter int NEST   = 2,    // maximum nesting depth
  parameter int EDGE   = 1,    // 1 = rising-edge capture, 0 = level-sensitive
  parameter int VBASE  = 480,  // vector table base address
  parameter int VSTEP  = 8     // spacing between vectors
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NITR-1:0]            irq,
  input  logic                       itr_en,
  input  logic                       mask_wr,
  input  logic [NITR-1:0]            mask_in,
  input  logic [MINSTW-1:0]          pc_addr,
  input  logic                       rti,
  output logic                       itr,
  output logic [MINSTW-1:0]          itr_vec,
  output logic [MINSTW-1:0]          rti_addr,
  output logic [NITR-1:0]            pend,
  output logic [$clog2(NEST+1)-1:0]  depth,
  output logic                       err
);

  localparam int DW = $clog2(NEST + 1);
  localparam int PW = $clog2(NITR);
  localparam int SW = (NEST > 1) ? $clog2(NEST) : 1;
  localparam logic [DW-1:0] NEST_D = DW'(NEST);

  typedef enum logic [1:0] {
    S_IDLE,  // no interrupt active, depth = 0
    S_FIRE,  // itr pulse cycle; push happens at the end of it
    S_NEST   // at least one handler active
  } state_t;

  state_t            state_q;
  state_t            state_d;

  logic [NITR-1:0]   irq_q;
  logic [NITR-1:0]   mask;
  logic [PW-1:0]     cand_q;

  logic              cand_valid;
  logic [PW-1:0]     cand_id;
  logic [NITR-1:0]   fire_clr;
  logic              fire_ok;

  logic              do_fire;
  logic              do_push;
  logic              do_pop;
  logic              rti_err;

  logic [SW-1:0]     push_idx;
  logic [SW-1:0]     top_idx;
  logic [SW-1:0]     below_idx;
  logic [PW-1:0]     pri_top;

  logic [MINSTW-1:0] ret_stack [NEST];
  logic [PW-1:0]     pri_stack [NEST];

  // Pick the highest-priority (lowest index) unmasked pending source.
  always_comb begin
    // NOTE: every signal written here gets a default first, so no path can
    // leave it unassigned and infer a latch.
    cand_valid = 1'b0;
    cand_id    = '0;
    for (int i = NITR - 1; i >= 0; i--) begin
      if (pend[i] && !mask[i] && itr_en) begin
        cand_valid = 1'b1;
        cand_id    = PW'(i);
      end
    end
  end

  // Stack pointers derived from the current depth, and the fire decision.
  always_comb begin
    push_idx  = SW'(depth);
    top_idx   = SW'(depth - DW'(1));
    below_idx = SW'(depth - DW'(2));
    pri_top   = pri_stack[top_idx];
    // Preemption needs strictly higher priority than the active handler.
    fire_ok   = cand_valid && (depth < NEST_D) && (state_q != S_FIRE) && !rti &&
                ((depth == '0) || (cand_id < pri_top));
    fire_clr  = do_fire ? (NITR'(1) << cand_id) : '0;
  end

  // State register.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic and datapath strobes.
  always_comb begin
    state_d = state_q;
    do_fire = 1'b0;
    do_push = 1'b0;
    do_pop  = 1'b0;
    rti_err = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (rti) begin
          rti_err = 1'b1;              // nothing to return from
        end else if (fire_ok) begin
          do_fire = 1'b1;
          state_d = S_FIRE;
        end
      end
      S_FIRE: begin
        do_push = 1'b1;
        state_d = S_NEST;
        if (rti) rti_err = 1'b1;       // return during the vector cycle is illegal
      end
      S_NEST: begin
        if (rti) begin
          do_pop = 1'b1;
          if (depth == DW'(1)) state_d = S_IDLE;
        end else if (fire_ok) begin
          do_fire = 1'b1;
          state_d = S_FIRE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Capture, mask, vector, depth, return-address and error registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      irq_q    <= '0;
      pend     <= '0;
      mask     <= '1;
      itr      <= 1'b0;
      itr_vec  <= '0;
      cand_q   <= '0;
      depth    <= '0;
      rti_addr <= '0;
      err      <= 1'b0;
    end else begin
      irq_q <= irq;
      if (EDGE != 0) begin
        // A new rising edge wins over the clear from firing the same source.
        pend <= (pend & ~fire_clr) | (irq & ~irq_q);
      end else begin
        pend <= irq;
      end

      if (mask_wr) mask <= mask_in;

      itr <= do_fire;
      if (do_fire) begin
        itr_vec <= MINSTW'(VBASE + int'(cand_id) * VSTEP);
        cand_q  <= cand_id;
      end

      if (do_push) begin
        depth    <= depth + DW'(1);
        rti_addr <= pc_addr;
      end else if (do_pop) begin
        depth <= depth - DW'(1);
        if (32'(depth) >= 32'd2) rti_addr <= ret_stack[below_idx];
        else                     rti_addr <= '0;
      end

      if (rti_err) err <= 1'b1;
    end
  end

  // Return-address and priority stacks.
  always_ff @(posedge clk) begin
    // NOTE: stack storage has no reset; depth alone says which entries are
    // valid, so clearing depth empties the stacks.
    if (do_push) begin
      ret_stack[push_idx] <= pc_addr;
      pri_stack[push_idx] <= cand_q;
    end
  end

endmodule

// File: doc/itr_ctrl.md
Name: itr_ctrl

Overview:
- Multi-source vectored interrupt controller for the fixed-point processor core. It generalises the core's single-line `itr` input to NITR prioritised, maskable sources with nesting.
- It adds a hardware return-address stack and a per-source vector address.
- It sits between external event sources and the core's PC mux: it drives the core's `itr` and the vector address, and it returns the saved PC on return-from-interrupt.

Parameters:
- MINSTW, 9: instruction address width.
- NITR, 4: number of interrupt sources (≥2).
- NEST, 2: maximum nesting depth (≥1).
- EDGE, 1: 1 = rising-edge capture, 0 = level-sensitive.
- VBASE, 480: vector table base address.
- VSTEP, 8: address spacing between vectors.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- irq  in  NITR  interrupt request lines; bit 0 has the highest priority.
- itr_en  in  1  global interrupt enable from the core.
- mask_wr  in  1  loads the mask register.
- mask_in  in  NITR  new mask value; 1 = masked.
- pc_addr  in  MINSTW  core's current instruction address, used as the return address.
- rti  in  1  return-from-interrupt pulse from the core.
- itr  out  1  one-cycle pulse; the core loads itr_vec into the PC.
- itr_vec  out  MINSTW  vector address.
- rti_addr  out  MINSTW  top of the return stack.
- pend  out  NITR  pending register.
- depth  out  $clog2(NEST+1)  current nesting level.
- err  out  1  sticky error flag.

Behaviour:
- One clock domain. All outputs are registered. rst is synchronous: on the rising edge with rst=1, pend=0, mask=all ones, itr=0, itr_vec=0, stacks empty, depth=0, rti_addr=0, err=0, irq_q=0, FSM=IDLE. This applies mid-ISR too: all nesting state is discarded.
- Capture with EDGE=1: pend[i] is set at an edge where irq[i]=1 and irq_q[i]=0. It is cleared at the edge that fires source i. Set wins over clear in the same cycle.
- Capture with EDGE=0: pend follows registered irq each cycle and is never cleared by firing. The source must drop before rti.
- Masked sources stay pending. mask_wr takes effect at the next edge.
- Eligibility, evaluated combinationally from registered state:
  - cand = lowest i with pend[i] & ~mask[i] & itr_en.
  - Fire when all of the following hold: cand exists, depth<NEST, state≠FIRE, rti=0, and (depth=0 or cand < id on top of the priority stack). Preemption requires strictly higher priority, so equal or lower priority waits.
- FSM states:
  - IDLE (depth=0) → FIRE when the fire condition holds.
  - FIRE: itr=1 for exactly one cycle and itr_vec=VBASE+cand*VSTEP, latched at entry. At the end of FIRE, pc_addr is pushed onto the return stack and cand onto the priority stack, and depth is incremented. Next state is NEST.
  - NEST (depth>0) → FIRE on a preempting candidate. On rti: pop both stacks and decrement depth; if depth becomes 0, go to IDLE.
- Latency (EDGE=1): irq rises, sampled at edge E → pend=1 after E → itr=1 during the cycle after E+1 → depth updated after E+2.
- rti_addr always shows the top of the return stack, and 0 when empty. On rti the core loads rti_addr in that cycle; the pop is visible next cycle.
- rti in the same cycle as a fire condition: the rti is processed, and the fire is evaluated again next cycle against the popped state.
- rti with depth=0: ignored, err←1. err stays set until reset.
- rti asserted during FIRE: ignored, err←1.
- Vector arithmetic is taken modulo 2^MINSTW, with no saturation.
- Stack storage is NEST entries each of MINSTW and $clog2(NITR) bits.

Test Plan:
1. Reset → itr=0, depth=0, pend=0, mask=4'b1111, err=0, rti_addr=0. Pulse irq[2] while masked → pend=4'b0100, no itr.
2. mask_in=0 with mask_wr, itr_en=1, pc_addr=9'h05A, irq[2] rising at edge E → itr high only in the cycle after E+1, itr_vec=496. After E+2: depth=1, rti_addr=0x05A, pend[2]=0.
3. Inside ISR 2 with pc_addr=0x1F3, raise irq[0] → itr_vec=480, depth=2, rti_addr=0x1F3. Then raise irq[1] → no fire (depth=NEST), pend[1] stays 1. rti → depth=1, rti_addr=0x05A. Next cycle irq[1] fires (1<2), itr_vec=488.
4. irq[1] and irq[3] rise in the same cycle → source 1 fires first. irq[3] is held while ISR 1 is active. After rti, source 3 fires with itr_vec=504.
5. rti with depth=0 → err=1 and no other state change. Assert rst mid-ISR with depth=2 → everything returns to reset values and err=0.
6. EDGE=0: hold irq[0] high, fire → depth=1 and pend[0] stays 1, with no re-fire of 0. Drop irq[0], then rti → depth=0 and no further itr. Also check itr_en=0 blocks firing while pend is set, and firing occurs one cycle after itr_en=1.
